// File: rtl/dmem_sum_master.sv
// dmem_sum_master: data-memory bus initiator that sums a block of words.
// On an accepted start it reads count consecutive words from base, one per
// cycle, accumulates them modulo 2^32, writes the total to dest and pulses done.
// Build option: define DMEM_SUM_OVF_EN to build the sticky carry-out flag (ovf);
// without it ovf is tied low and no carry logic exists.
module dmem_sum_master #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic [31:0]      base,
  input  logic [31:0]      dest,
  input  logic [CNT_W-1:0] count,
  input  logic [31:0]      mem_din,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_dout,
  output logic             mem_we,
  output logic             busy,
  output logic             done,
  output logic [31:0]      sum,
  output logic             ovf
);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      acc_q;
  logic [31:0]      base_q;
  logic [31:0]      dest_q;
  logic [31:0]      sum_q;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] count_q;

  logic             accept;
  logic             last_read;
  logic [31:0]      read_addr;
  logic [31:0]      acc_next;

  // A job is taken only from IDLE; start at any other time is dropped.
  assign accept    = (state_q == StIdle) && start;
  assign last_read = (idx_q == (count_q - CNT_W'(1)));
  // Word index scaled to a byte offset; the add wraps at 2^32.
  assign read_addr = base_q + (32'(idx_q) << 2);

`ifdef DMEM_SUM_OVF_EN
  logic [32:0] add_full;
  logic        carry;

  // 33-bit add so the carry out of bit 31 is visible.
  assign add_full = {1'b0, acc_q} + {1'b0, mem_din};
  assign acc_next = add_full[31:0];
  assign carry    = add_full[32];
`else
  assign acc_next = acc_q + mem_din;
`endif

  // State register; reset aborts any job immediately.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and bus outputs, all decoded from the current state.
  always_comb begin
    state_d  = state_q;
    mem_addr = 32'h0;
    mem_dout = 32'h0;
    mem_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (count != '0) ? StRead : StWrite;
        end
      end
      StRead: begin
        busy     = 1'b1;
        mem_addr = read_addr;
        if (last_read) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        busy     = 1'b1;
        mem_addr = dest_q;
        mem_dout = acc_q;
        mem_we   = 1'b1;
        state_d  = StDone;
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Job parameters are latched at accept so input changes while busy are ignored.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      base_q  <= 32'h0;
      dest_q  <= 32'h0;
      count_q <= '0;
    end else if (accept) begin
      base_q  <= base;
      dest_q  <= dest;
      count_q <= count;
    end
  end

  // Accumulator and read index: cleared at accept, advanced once per READ cycle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      acc_q <= 32'h0;
      idx_q <= '0;
    end else if (accept) begin
      acc_q <= 32'h0;
      idx_q <= '0;
    end else if (state_q == StRead) begin
      acc_q <= acc_next;
      idx_q <= idx_q + CNT_W'(1);
    end
  end

  // Result register: updated at the edge that commits the memory write.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sum_q <= 32'h0;
    end else if (state_q == StWrite) begin
      sum_q <= acc_q;
    end
  end

  assign sum = sum_q;

`ifdef DMEM_SUM_OVF_EN
  logic ovf_q;

  // Sticky carry flag: cleared at accept, set by any overflowing READ add.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= 1'b0;
    end else if ((state_q == StRead) && carry) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_sum_master.sv
// Testbench for dmem_sum_master: a per-job expected-transaction queue is built
// from the memory contents when a start is accepted and compared every cycle.
module tb_dmem_sum_master;

  localparam int unsigned CW = 5;

  logic          clk   = 1'b0;
  logic          clrn  = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   base  = 32'h0;
  logic [31:0]   dest  = 32'h0;
  logic [CW-1:0] count = '0;
  logic [31:0]   mem_din;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_dout;
  logic          mem_we;
  logic          busy;
  logic          done;
  logic [31:0]   sum;
  logic          ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_sum_master #(.CNT_W(CW)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .start    (start),
    .base     (base),
    .dest     (dest),
    .count    (count),
    .mem_din  (mem_din),
    .mem_addr (mem_addr),
    .mem_dout (mem_dout),
    .mem_we   (mem_we),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .ovf      (ovf)
  );

  // 256-word memory; address bits [9:2] select the word, so addresses alias.
  logic [31:0] mem [256];
  logic        pl_we   = 1'b0;
  logic [7:0]  pl_idx  = 8'h0;
  logic [31:0] pl_data = 32'h0;

  assign mem_din = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (pl_we) mem[pl_idx] <= pl_data;
    else if (mem_we) mem[mem_addr[9:2]] <= mem_dout;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected bus activity, one record per busy cycle.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] dout;
    logic        we;
    logic        dn;
    logic [31:0] rsum;
    logic        rovf;
  } rec_t;

  rec_t        q[$];
  logic [31:0] exp_sum = 32'h0;
  logic        exp_ovf = 1'b0;

  task automatic build_job(input logic [31:0] b, input logic [31:0] d, input int n);
    rec_t        r;
    logic [31:0] a = 32'h0;
    logic [32:0] t;
    logic        o = 1'b0;
    logic [31:0] ad;
    for (int i = 0; i < n; i++) begin
      ad = b + 32'(4 * i);
      t  = {1'b0, a} + {1'b0, mem[ad[9:2]]};
      if (t[32]) o = 1'b1;
      a = t[31:0];
      r = '{addr: ad, dout: 32'h0, we: 1'b0, dn: 1'b0, rsum: 32'h0, rovf: 1'b0};
      q.push_back(r);
    end
`ifndef DMEM_SUM_OVF_EN
    o = 1'b0;
`endif
    r = '{addr: d, dout: a, we: 1'b1, dn: 1'b0, rsum: a, rovf: o};
    q.push_back(r);
    r = '{addr: 32'h0, dout: 32'h0, we: 1'b0, dn: 1'b1, rsum: a, rovf: o};
    q.push_back(r);
  endtask

  // Model advance: retire one busy cycle per edge, or accept a new job when idle.
  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q.delete();
      exp_sum <= 32'h0;
      exp_ovf <= 1'b0;
    end else if (q.size() != 0) begin
      if (q[0].we) begin
        exp_sum <= q[0].rsum;
        exp_ovf <= q[0].rovf;
      end
      void'(q.pop_front());
    end else if (start) begin
      build_job(base, dest, int'(count));
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!clrn) begin
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_dout", mem_dout, 32'h0);
      chk("rst_we", mem_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 32'h0);
      chk("rst_ovf", ovf, 0);
    end else if (q.size() != 0) begin
      chk("addr", mem_addr, q[0].addr);
      chk("we", mem_we, q[0].we);
      chk("done", done, q[0].dn);
      chk("busy", busy, 1);
      if (q[0].we) chk("dout", mem_dout, q[0].dout);
      if (q[0].dn) begin
        chk("done_sum", sum, exp_sum);
        chk("done_ovf", ovf, exp_ovf);
      end
    end else begin
      chk("idle_addr", mem_addr, 32'h0);
      chk("idle_dout", mem_dout, 32'h0);
      chk("idle_we", mem_we, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_sum", sum, exp_sum);
      chk("idle_ovf", ovf, exp_ovf);
    end
  end

  // All drivers act 2 time units after a rising edge.
  task automatic poke(input logic [7:0] idx, input logic [31:0] data);
    pl_idx  = idx;
    pl_data = data;
    pl_we   = 1'b1;
    @(posedge clk);
    #2 pl_we = 1'b0;
  endtask

  // Start a job, scramble inputs once accepted, return cycles until done.
  task automatic run_job(input logic [31:0] b, input logic [31:0] d,
                         input logic [CW-1:0] c, output int lat);
    base  = b;
    dest  = d;
    count = c;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    base  = $urandom;
    dest  = $urandom;
    count = CW'($urandom);
    lat   = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (lat > 100) begin
        checks++;
        failures++;
        $display("FAIL done_timeout: got no done expected done within 100 cycles");
        break;
      end
    end
    @(posedge clk);
    #2;
  endtask

  int lat;
  int dn_cyc[$];
  logic [CW-1:0] rc;

  initial begin
    // Reset held while memory is filled with random data.
    @(posedge clk);
    #2;
    for (int i = 0; i < 256; i++) poke(8'(i), $urandom);
    clrn = 1'b1;
    @(posedge clk);
    #2;

    // Four-word sum.
    poke(8'h14, 32'ha3);
    poke(8'h15, 32'h27);
    poke(8'h16, 32'h79);
    poke(8'h17, 32'h115);
    run_job(32'h50, 32'h60, CW'(4), lat);
    chk("t1_latency", 32'(lat), 32'd6);
    chk("t1_sum", sum, 32'h258);
    chk("t1_mem", mem[8'h18], 32'h258);
    chk("t1_ovf", ovf, 0);

    // Zero-length job writes 0.
    poke(8'h10, 32'h12345678);
    run_job(32'h0, 32'h40, CW'(0), lat);
    chk("t2_latency", 32'(lat), 32'd2);
    chk("t2_sum", sum, 32'h0);
    chk("t2_mem", mem[8'h10], 32'h0);

    // Carry out of bit 31.
    poke(8'h00, 32'hffffffff);
    poke(8'h01, 32'h00000002);
    run_job(32'h0, 32'h80, CW'(2), lat);
    chk("t3_sum", sum, 32'h1);
`ifdef DMEM_SUM_OVF_EN
    chk("t3_ovf", ovf, 1);
`else
    chk("t3_ovf", ovf, 0);
`endif

    // Reset in the middle of READ.
    poke(8'h30, 32'hdeadbeef);
    poke(8'h40, 32'd1);
    poke(8'h41, 32'd2);
    poke(8'h42, 32'd3);
    poke(8'h43, 32'd4);
    base  = 32'h100;
    dest  = 32'hc0;
    count = CW'(4);
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    @(posedge clk);
    #2;
    chk("t4_mid_busy", busy, 1);
    clrn = 1'b0;
    #1;
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_sum", sum, 32'h0);
    chk("t4_rst_we", mem_we, 0);
    @(posedge clk);
    #2 clrn = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    chk("t4_dest_kept", mem[8'h30], 32'hdeadbeef);
    run_job(32'h100, 32'hc0, CW'(4), lat);
    chk("t4_latency", 32'(lat), 32'd6);
    chk("t4_mem", mem[8'h30], 32'd10);

    // start held high, count=1: back-to-back jobs, base changing while busy.
    base  = 32'h200;
    dest  = 32'h300;
    count = CW'(1);
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dn_cyc.push_back(i);
      @(posedge clk);
      #2;
      base = {22'h0, 8'($urandom), 2'b00};
    end
    start = 1'b0;
    chk("t5_done_count", 32'(dn_cyc.size()), 32'd5);
    for (int i = 1; i < dn_cyc.size(); i++) begin
      chk("t5_spacing", 32'(dn_cyc[i] - dn_cyc[i-1]), 32'd4);
    end
    repeat (6) @(posedge clk);
    #2;

    // Address wrap-around past 0xFFFFFFFC.
    poke(8'hff, 32'h11111111);
    poke(8'h00, 32'h22222222);
    run_job(32'hfffffffc, 32'h84, CW'(2), lat);
    chk("t6_sum", sum, 32'h33333333);
    chk("t6_mem", mem[8'h21], 32'h33333333);

    // Random jobs.
    for (int j = 0; j < 25; j++) begin
      rc = CW'($urandom);
      run_job($urandom, $urandom, rc, lat);
      chk("rand_latency", 32'(lat), 32'(rc) + 32'd2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
